bus_region_decoder: RTL and testbench

//  Parametrised 8088 bus-side glue: registered address capture on ALE, N-region chip-select decode
//  (memory or I/O space), per-region wait-state insertion on READY, and transceiver enable/direction.

---
 rtl/bus_dec_pkg.sv | 24 ++
 rtl/bus_ws_counter.sv | 25 ++
 rtl/bus_region_decoder.sv | 162 ++++++++++++++++
 tb/tb_bus_region_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_dec_pkg.sv
// Shared types for the 8088 bus region decoder: FSM states, region descriptor
// and the priority one-hot helper. Widths here size the region table and the
// priority function, so the top-level defaults track them.
package bus_dec_pkg;

  localparam int DEC_NREG = 4;
  localparam int DEC_AW   = 20;
  localparam int DEC_WSW  = 3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} ws_state_e;

  typedef struct packed {
    logic                iom;
    logic [DEC_AW-1:0]   base;
    logic [DEC_AW-1:0]   mask;
    logic [DEC_WSW-1:0]  ws;
  } region_t;

  // Keep only the lowest set bit: lowest region index wins.
  function automatic logic [DEC_NREG-1:0] pri_onehot(input logic [DEC_NREG-1:0] v);
    pri_onehot = v & (~v + DEC_NREG'(1));
  endfunction

endpackage

// File: rtl/bus_ws_counter.sv
// Loadable wait-state down-counter. Saturates at zero so a stray decrement
// can never wrap into a long bogus wait.
module bus_ws_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge CLK) begin
    if (!RESET)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bus_region_decoder.sv
// 8088 bus-side glue: ALE address capture, priority region chip-select decode,
// per-region wait states on READY, and transceiver enable/direction.
// Optional overlap checker enabled by defining BUS_DEC_OVERLAP_CHK_EN; without
// it MULTI_HIT is tied low.
module bus_region_decoder
  import bus_dec_pkg::*;
#(
  parameter int NREG = DEC_NREG,
  parameter int AW   = DEC_AW,
  parameter int WSW  = DEC_WSW,
  parameter logic [NREG-1:0]          REG_IOM  = 4'b1100,
  parameter logic [NREG-1:0][AW-1:0]  REG_BASE = {20'h0FF00, 20'h01C00, 20'h80000, 20'h00000},
  parameter logic [NREG-1:0][AW-1:0]  REG_MASK = {20'h0FFF0, 20'h0FE00, 20'h80000, 20'h80000},
  parameter logic [NREG-1:0][WSW-1:0] REG_WS   = {3'd3, 3'd1, 3'd2, 3'd0}
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ALE,
  input  logic            IOM,
  input  logic [AW-1:0]   A_IN,
  input  logic            RD_N,
  input  logic            WR_N,
  input  logic            DTR,
  input  logic            DEN,
  output logic [AW-1:0]   ADDR,
  output logic [NREG-1:0] CS,
  output logic            READY,
  output logic            ERR,
  output logic            XCVR_OE,
  output logic            XCVR_DIR,
  output logic            MULTI_HIT
);

  region_t            regs [NREG];
  logic               iom_q;
  logic [NREG-1:0]    hit, sel;
  logic [DEC_WSW-1:0] sel_ws;
  logic               strobe;
  ws_state_e          state_q, state_d;
  logic               ready_d, err_d;
  logic               ws_load, ws_dec, ws_zero;

  assign strobe = ~RD_N | ~WR_N;

  // Region table and per-region address/space match.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign regs[i] = '{iom:  REG_IOM[i],
                       base: DEC_AW'(REG_BASE[i]),
                       mask: DEC_AW'(REG_MASK[i]),
                       ws:   DEC_WSW'(REG_WS[i])};
    assign hit[i]  = (iom_q == regs[i].iom) &&
                     ((DEC_AW'(ADDR) & regs[i].mask) == (regs[i].base & regs[i].mask));
  end

  assign sel = NREG'(pri_onehot(DEC_NREG'(hit)));

  // Wait-state count of the winning region (zero when nothing hits).
  always_comb begin
    sel_ws = '0;
    for (int i = 0; i < NREG; i++)
      if (sel[i]) sel_ws |= regs[i].ws;
  end

  // Address/space capture on ALE; held until the next ALE.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ADDR  <= '0;
      iom_q <= 1'b0;
    end else if (ALE) begin
      ADDR  <= A_IN;
      iom_q <= IOM;
    end
  end

  // Registered chip selects, forced off while ALE is high.
  always_ff @(posedge CLK) begin
    if (!RESET)   CS <= '0;
    else if (ALE) CS <= '0;
    else          CS <= sel;
  end

  bus_ws_counter #(.W(WSW)) u_ws_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (ws_load),
    .load_val (WSW'(sel_ws) - WSW'(1)),
    .dec      (ws_dec),
    .zero     (ws_zero)
  );

  // FSM state, READY and ERR registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      READY   <= 1'b1;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      READY   <= ready_d;
      ERR     <= err_d;
    end
  end

  // Next state: a new ALE aborts any cycle in progress; unmatched strobes go
  // straight to DONE with ERR so the CPU is never left waiting.
  always_comb begin
    state_d = state_q;
    ready_d = READY;
    err_d   = ERR;
    ws_load = 1'b0;
    ws_dec  = 1'b0;
    if (ALE) begin
      state_d = IDLE;
      ready_d = 1'b1;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (strobe) begin
          if ((|sel) && sel_ws != '0) begin
            ws_load = 1'b1;
            ready_d = 1'b0;
            state_d = WAIT;
          end else begin
            ready_d = 1'b1;
            err_d   = ~|sel;
            state_d = DONE;
          end
        end
        WAIT: if (ws_zero) begin
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          ws_dec  = 1'b1;
        end
        DONE: begin
          ready_d = 1'b1;
          if (!strobe) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            err_d   = ~|CS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BUS_DEC_OVERLAP_CHK_EN
  // Sticky flag: more than one region matched on a decode edge.
  always_ff @(posedge CLK) begin
    if (!RESET)                                   MULTI_HIT <= 1'b0;
    else if (!ALE && ((hit & (hit - NREG'(1))) != '0)) MULTI_HIT <= 1'b1;
  end
`else
  assign MULTI_HIT = 1'b0;
`endif

  assign XCVR_DIR = DTR;
  assign XCVR_OE  = ~DEN & (|CS);

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: reset, memory/I-O decode, wait-state
// lengths, unmatched-access error, ALE abort, reset mid-wait and overlap flag.
module tb_bus_region_decoder;

  logic        CLK = 1'b0;
  logic        RESET, ALE, IOM, RD_N, WR_N, DTR, DEN;
  logic [19:0] A_IN;
  logic [19:0] ADDR;
  logic [3:0]  CS;
  logic        READY, ERR, XCVR_OE, XCVR_DIR, MULTI_HIT;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  bus_region_decoder dut (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .A_IN(A_IN),
    .RD_N(RD_N), .WR_N(WR_N), .DTR(DTR), .DEN(DEN),
    .ADDR(ADDR), .CS(CS), .READY(READY), .ERR(ERR),
    .XCVR_OE(XCVR_OE), .XCVR_DIR(XCVR_DIR), .MULTI_HIT(MULTI_HIT)
  );

`ifdef BUS_DEC_OVERLAP_CHK_EN
  logic [19:0] ADDR2;
  logic [3:0]  CS2;
  logic        READY2, ERR2, OE2, DIR2, MH2;
  bus_region_decoder #(
    .REG_MASK({20'h0FFF0, 20'h00000, 20'h80000, 20'h80000})
  ) dut_ovl (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .A_IN(A_IN),
    .RD_N(RD_N), .WR_N(WR_N), .DTR(DTR), .DEN(DEN),
    .ADDR(ADDR2), .CS(CS2), .READY(READY2), .ERR(ERR2),
    .XCVR_OE(OE2), .XCVR_DIR(DIR2), .MULTI_HIT(MH2)
  );
`endif

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick;
    @(posedge CLK); #1;
  endtask

  // Address phase: ALE edge then first decode edge.
  task automatic addr_phase(input logic [19:0] a, input logic iom);
    ALE = 1'b1; A_IN = a; IOM = iom;
    tick();
    ALE = 1'b0;
    tick();
  endtask

  // Hold strobes for 8 edges and count cycles with READY low.
  task automatic count_lows(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (READY === 1'b0) n++;
    end
  endtask

  task automatic release_bus;
    RD_N = 1'b1; WR_N = 1'b1; DEN = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    RESET = 1'b0; ALE = 1'b0; IOM = 1'b0; A_IN = '0;
    RD_N = 1'b1; WR_N = 1'b1; DTR = 1'b0; DEN = 1'b1;
    tick(); tick();
    checks++; if (CS !== 4'b0000) $display("FAIL reset_cs got=%b exp=0000", CS); else passed++;
    checks++; if (READY !== 1'b1) $display("FAIL reset_ready got=%b exp=1", READY); else passed++;
    checks++; if (ERR !== 1'b0) $display("FAIL reset_err got=%b exp=0", ERR); else passed++;
    checks++; if (ADDR !== 20'h0) $display("FAIL reset_addr got=%h exp=00000", ADDR); else passed++;
    checks++; if (MULTI_HIT !== 1'b0) $display("FAIL reset_multi got=%b exp=0", MULTI_HIT); else passed++;
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_mem_read;
    int n;
    ALE = 1'b1; A_IN = 20'h12345; IOM = 1'b0;
    tick();
    checks++; if (ADDR !== 20'h12345) $display("FAIL mr_addr got=%h exp=12345", ADDR); else passed++;
    checks++; if (CS !== 4'b0000) $display("FAIL mr_cs_during_ale got=%b exp=0000", CS); else passed++;
    ALE = 1'b0;
    tick();
    checks++; if (CS !== 4'b0001) $display("FAIL mr_cs got=%b exp=0001", CS); else passed++;
    RD_N = 1'b0; DTR = 1'b0; DEN = 1'b0;
    count_lows(n);
    checks++; if (n !== 0) $display("FAIL mr_ready_lows got=%0d exp=0", n); else passed++;
    checks++; if (XCVR_OE !== 1'b1) $display("FAIL mr_oe got=%b exp=1", XCVR_OE); else passed++;
    checks++; if (XCVR_DIR !== 1'b0) $display("FAIL mr_dir got=%b exp=0", XCVR_DIR); else passed++;
    checks++; if (ERR !== 1'b0) $display("FAIL mr_err got=%b exp=0", ERR); else passed++;
    release_bus();
  endtask

  task automatic test_mem_write;
    int n;
    addr_phase(20'h80010, 1'b0);
    checks++; if (CS !== 4'b0010) $display("FAIL mw_cs got=%b exp=0010", CS); else passed++;
    WR_N = 1'b0; DTR = 1'b1; DEN = 1'b0;
    tick();
    checks++; if (READY !== 1'b0) $display("FAIL mw_ready_first got=%b exp=0", READY); else passed++;
    checks++; if (XCVR_DIR !== 1'b1) $display("FAIL mw_dir got=%b exp=1", XCVR_DIR); else passed++;
    count_lows(n);
    checks++; if (n !== 1) $display("FAIL mw_ready_lows_after_first got=%0d exp=1", n); else passed++;
    checks++; if (READY !== 1'b1) $display("FAIL mw_ready_end got=%b exp=1", READY); else passed++;
    release_bus();
  endtask

  task automatic test_io_waits;
    int n;
    addr_phase(20'h0FF05, 1'b1);
    checks++; if (CS !== 4'b1000) $display("FAIL io3_cs got=%b exp=1000", CS); else passed++;
    RD_N = 1'b0; DTR = 1'b0; DEN = 1'b0;
    count_lows(n);
    checks++; if (n !== 3) $display("FAIL io3_ready_lows got=%0d exp=3", n); else passed++;
    release_bus();
    addr_phase(20'h01C40, 1'b1);
    checks++; if (CS !== 4'b0100) $display("FAIL io2_cs got=%b exp=0100", CS); else passed++;
    RD_N = 1'b0; DEN = 1'b0;
    count_lows(n);
    checks++; if (n !== 1) $display("FAIL io2_ready_lows got=%0d exp=1", n); else passed++;
    release_bus();
  endtask

  task automatic test_unmatched;
    addr_phase(20'h00300, 1'b1);
    checks++; if (CS !== 4'b0000) $display("FAIL um_cs got=%b exp=0000", CS); else passed++;
    RD_N = 1'b0; DEN = 1'b0;
    tick();
    checks++; if (ERR !== 1'b1) $display("FAIL um_err got=%b exp=1", ERR); else passed++;
    checks++; if (READY !== 1'b1) $display("FAIL um_ready got=%b exp=1", READY); else passed++;
    checks++; if (XCVR_OE !== 1'b0) $display("FAIL um_oe got=%b exp=0", XCVR_OE); else passed++;
    tick();
    checks++; if (ERR !== 1'b1) $display("FAIL um_err_hold got=%b exp=1", ERR); else passed++;
    RD_N = 1'b1;
    tick();
    checks++; if (ERR !== 1'b0) $display("FAIL um_err_clear got=%b exp=0", ERR); else passed++;
    DEN = 1'b1;
    tick();
  endtask

  task automatic test_both_strobes;
    int n;
    addr_phase(20'h12345, 1'b0);
    RD_N = 1'b0; WR_N = 1'b0;
    count_lows(n);
    checks++; if (n !== 0) $display("FAIL bs_ready_lows got=%0d exp=0", n); else passed++;
    checks++; if (ERR !== 1'b0) $display("FAIL bs_err got=%b exp=0", ERR); else passed++;
    release_bus();
  endtask

  task automatic test_ale_abort;
    addr_phase(20'h0FF05, 1'b1);
    RD_N = 1'b0;
    tick();
    checks++; if (READY !== 1'b0) $display("FAIL ab_ready_wait got=%b exp=0", READY); else passed++;
    RD_N = 1'b1; ALE = 1'b1; A_IN = 20'h12345; IOM = 1'b0;
    tick();
    checks++; if (READY !== 1'b1) $display("FAIL ab_ready got=%b exp=1", READY); else passed++;
    checks++; if (CS !== 4'b0000) $display("FAIL ab_cs got=%b exp=0000", CS); else passed++;
    checks++; if (ADDR !== 20'h12345) $display("FAIL ab_addr got=%h exp=12345", ADDR); else passed++;
    ALE = 1'b0;
    tick();
    checks++; if (CS !== 4'b0001) $display("FAIL ab_cs_new got=%b exp=0001", CS); else passed++;
  endtask

  task automatic test_reset_mid_wait;
    addr_phase(20'h0FF05, 1'b1);
    RD_N = 1'b0;
    tick();
    tick();
    checks++; if (READY !== 1'b0) $display("FAIL rw_ready_2nd got=%b exp=0", READY); else passed++;
    RESET = 1'b0;
    tick();
    checks++; if (READY !== 1'b1) $display("FAIL rw_ready got=%b exp=1", READY); else passed++;
    checks++; if (CS !== 4'b0000) $display("FAIL rw_cs got=%b exp=0000", CS); else passed++;
    checks++; if (ADDR !== 20'h0) $display("FAIL rw_addr got=%h exp=00000", ADDR); else passed++;
    RESET = 1'b1; RD_N = 1'b1;
    tick();
  endtask

  task automatic test_overlap;
    addr_phase(20'h0FF05, 1'b1);
    checks++; if (MULTI_HIT !== 1'b0) $display("FAIL ov_multi_nominal got=%b exp=0", MULTI_HIT); else passed++;
`ifdef BUS_DEC_OVERLAP_CHK_EN
    checks++; if (CS2 !== 4'b0100) $display("FAIL ov_cs got=%b exp=0100", CS2); else passed++;
    checks++; if (MH2 !== 1'b1) $display("FAIL ov_multi got=%b exp=1", MH2); else passed++;
    addr_phase(20'h12345, 1'b0);
    checks++; if (MH2 !== 1'b1) $display("FAIL ov_multi_sticky got=%b exp=1", MH2); else passed++;
    RESET = 1'b0;
    tick();
    checks++; if (MH2 !== 1'b0) $display("FAIL ov_multi_reset got=%b exp=0", MH2); else passed++;
    RESET = 1'b1;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_waits();
    test_unmatched();
    test_both_strobes();
    test_ale_abort();
    test_reset_mid_wait();
    test_overlap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
